// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush,
// data-memory wait freeze with timeout, and saturating stall/flush counters.
// Control outputs are combinational from the registered state and the
// current inputs, so the pipeline reacts in the same cycle.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_uses_rs2,
  input  logic        exmem_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        freeze,
  output logic        mem_err,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        lu_done_q;

  logic        lu_hazard;
  logic        lu_stall;
  logic        run_rules;

  assign lu_hazard = idex_memread && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) ||
                      (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  // Next-state and control decode; priority ERROR > mem stall > branch > load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    freeze      = 1'b0;
    lu_stall    = 1'b0;
    run_rules   = 1'b0;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      ERROR: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        freeze     = 1'b1;
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          freeze     = 1'b1;
          if (wait_cnt_q == 8'(TIMEOUT)) begin
            state_d = ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          run_rules  = 1'b1;
        end
      end
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // A branch held across a memory stall is honoured here on the release
    // cycle. A load-use stall is issued once; the bubble it inserts into
    // ID/EX clears the hazard, so a still-asserted hazard on the following
    // cycle is the same occurrence and must not stall again.
    if (run_rules) begin
      if (exmem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (lu_hazard && !lu_done_q) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        lu_stall   = 1'b1;
      end
    end
  end

  // State, wait counter, sticky error and saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lu_done_q  <= lu_stall;
      if (state_d == ERROR) begin
        mem_err_q <= 1'b1;
      end
      if (!pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (exmem_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign mem_err   = mem_err_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4) with hand-computed
// expectations. Control vector order: {pc_write, ifid_write, ifid_flush,
// idex_flush, exmem_flush, freeze}.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        idex_memread;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_uses_rs2;
  logic        exmem_branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        freeze;
  logic        mem_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] CTL_DEF    = 6'b110000;
  localparam logic [5:0] CTL_LU     = 6'b000100;
  localparam logic [5:0] CTL_BR     = 6'b111110;
  localparam logic [5:0] CTL_FROZEN = 6'b000001;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .idex_memread       (idex_memread),
    .idex_rd            (idex_rd),
    .ifid_rs1           (ifid_rs1),
    .ifid_rs2           (ifid_rs2),
    .ifid_uses_rs2      (ifid_uses_rs2),
    .exmem_branch_taken (exmem_branch_taken),
    .dmem_req           (dmem_req),
    .dmem_ready         (dmem_ready),
    .pc_write           (pc_write),
    .ifid_write         (ifid_write),
    .ifid_flush         (ifid_flush),
    .idex_flush         (idex_flush),
    .exmem_flush        (exmem_flush),
    .freeze             (freeze),
    .mem_err            (mem_err),
    .state              (state),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze},
        {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u2, input logic br,
                     input logic req, input logic rdy);
    idex_memread       = mr;
    idex_rd            = rd;
    ifid_rs1           = rs1;
    ifid_rs2           = rs2;
    ifid_uses_rs2      = u2;
    exmem_branch_taken = br;
    dmem_req           = req;
    dmem_ready         = rdy;
    #1;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk_ctl("rst_ctl", CTL_DEF);
    reset = 1'b0;
    tick();
    chk_ctl("idle_ctl", CTL_DEF);

    // Load-use through rs2, held for two cycles: only the first stalls.
    drv(1, 5, 3, 5, 1, 0, 0, 0);
    chk_ctl("lu_rs2_ctl", CTL_LU);
    tick();
    chk("lu_rs2_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    chk_ctl("lu_held_ctl", CTL_DEF);
    tick();
    chk("lu_held_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // rd = x0 never hazards.
    drv(1, 0, 0, 0, 1, 0, 0, 0);
    chk_ctl("lu_x0_ctl", CTL_DEF);
    tick();
    chk("lu_x0_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // rs1 match stalls even without rs2 use.
    drv(1, 7, 7, 2, 0, 0, 0, 0);
    chk_ctl("lu_rs1_ctl", CTL_LU);
    tick();
    chk("lu_rs1_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // rs2 match ignored when rs2 is not read; non-load never hazards.
    drv(1, 9, 1, 9, 0, 0, 0, 0);
    chk_ctl("lu_rs2_unused_ctl", CTL_DEF);
    drv(0, 9, 9, 9, 1, 0, 0, 0);
    chk_ctl("lu_noload_ctl", CTL_DEF);
    tick();
    chk("lu_none_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Taken branch in RUN.
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    chk_ctl("br_ctl", CTL_BR);
    tick();
    chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset between clock edges clears counters at once.
    reset = 1'b1;
    #1;
    chk("async_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    reset = 1'b0;
    #1;

    // Memory stall for 3 cycles, release on the 4th.
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    chk_ctl("mem_c1_ctl", CTL_FROZEN);
    tick();
    chk("mem_c1_state", {30'd0, state}, 32'd1);
    chk_ctl("mem_c2_ctl", CTL_FROZEN);
    tick();
    chk_ctl("mem_c3_ctl", CTL_FROZEN);
    tick();
    chk("mem_c3_state", {30'd0, state}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 1, 1);
    chk_ctl("mem_release_ctl", CTL_DEF);
    tick();
    chk("mem_release_state", {30'd0, state}, 32'd0);
    chk("mem_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Branch + load-use + memory stall together.
    rst_pulse();
    drv(1, 5, 5, 0, 0, 1, 1, 0);
    chk_ctl("sim_frozen_ctl", CTL_FROZEN);
    tick();
    drv(1, 5, 5, 0, 0, 1, 1, 1);
    chk_ctl("sim_release_ctl", CTL_BR);
    tick();
    chk("sim_state", {30'd0, state}, 32'd0);
    chk("sim_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("sim_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Timeout: ERROR after the 5th frozen cycle.
    rst_pulse();
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) tick();
    chk("to_c4_state", {30'd0, state}, 32'd1);
    chk("to_c4_mem_err", {31'd0, mem_err}, 32'd0);
    tick();
    chk("to_state", {30'd0, state}, 32'd2);
    chk("to_mem_err", {31'd0, mem_err}, 32'd1);
    drv(1, 5, 5, 0, 0, 1, 1, 1);
    chk_ctl("err_frozen_ctl", CTL_FROZEN);
    tick();
    chk("err_stuck_state", {30'd0, state}, 32'd2);
    chk_ctl("err_stuck_ctl", CTL_FROZEN);
    reset = 1'b1;
    #1;
    chk("err_rst_state", {30'd0, state}, 32'd0);
    chk("err_rst_mem_err", {31'd0, mem_err}, 32'd0);
    chk_ctl("err_rst_ctl", CTL_BR);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during MEM_WAIT leaves no freeze.
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("wait_rst_state", {30'd0, state}, 32'd0);
    chk_ctl("wait_rst_ctl", CTL_DEF);
    reset = 1'b0;
    #1;

    // Stall counter saturation.
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (65545) tick();
    chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    tick();
    chk("sat_hold_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum number of MEM_WAIT cycles before the error state; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 idex_memread  input  1  instruction in EX is a load.
REQ-005 idex_rd  input  5  destination register of the instruction in EX.
REQ-006 ifid_rs1, ifid_rs2  input  5 each  source registers of the instruction in ID.
REQ-007 ifid_uses_rs2  input  1  instruction in ID reads rs2 (R/S/B formats).
REQ-008 exmem_branch_taken  input  1  branch in MEM resolved taken this cycle.
REQ-009 dmem_req  input  1  instruction in MEM accesses data memory this cycle.
REQ-010 dmem_ready  input  1  data memory completes the access this cycle.
REQ-011 pc_write, ifid_write  output  1 each  PC and IF/ID load enables.
REQ-012 ifid_flush, idex_flush, exmem_flush  output  1 each  zero the named register's control bits (bubble) at the next edge.
REQ-013 freeze  output  1  hold ID/EX, EX/MEM and MEM/WB contents (load enables low).
REQ-014 mem_err  output  1  sticky memory-timeout error.
REQ-015 state  output  2  FSM state: RUN=0, MEM_WAIT=1, ERROR=2.
REQ-016 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-017 The FSM state shall be registered; all control outputs shall be combinational from state and current inputs (same-cycle response).
REQ-018 Default (RUN, no event): pc_write=1, ifid_write=1, all flushes=0, freeze=0.
REQ-019 Memory stall: in RUN with dmem_req=1 and dmem_ready=0 → pc_write=0, ifid_write=0, freeze=1, flushes=0; next state MEM_WAIT; wait_cnt loads 1.
REQ-020 In MEM_WAIT with dmem_ready=0 → same outputs as REQ-019; wait_cnt increments.
REQ-021 In MEM_WAIT with dmem_ready=1 → default outputs (release cycle), with branch/load-use rules applied as in RUN; next state RUN.
REQ-022 In MEM_WAIT, if dmem_ready=0 while wait_cnt==TIMEOUT → next state ERROR.
REQ-023 ERROR: pc_write=0, ifid_write=0, freeze=1, flushes=0, mem_err=1; the block leaves ERROR only on reset.
REQ-024 Branch flush: in RUN or on a MEM_WAIT release cycle with exmem_branch_taken=1 → ifid_flush=1, idex_flush=1, exmem_flush=1, pc_write=1, ifid_write=1.
REQ-025 Load-use hazard = idex_memread & (idex_rd!=0) & (idex_rd==ifid_rs1 | (ifid_uses_rs2 & idex_rd==ifid_rs2)).
REQ-026 On a load-use hazard with no branch and no memory stall → pc_write=0, ifid_write=0, idex_flush=1, exactly one cycle per hazard occurrence.
REQ-027 Priority: ERROR > memory stall (REQ-019/020) > branch flush > load-use > default; a branch coincident with a memory stall is applied on the release cycle.
REQ-028 stall_cnt shall increment every cycle pc_write=0 and saturate at 0xFFFF.
REQ-029 flush_cnt shall increment every cycle exmem_flush=1 and saturate at 0xFFFF.
REQ-030 wait_cnt is 8 bits, internal, and cleared on entry to RUN.

Reset
REQ-031 On reset assertion, regardless of clk: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0; outputs shall then follow REQ-018..026 from the current inputs.
REQ-032 Reset during MEM_WAIT or ERROR shall return the block to RUN immediately, with no residual freeze.

Verification
REQ-033 Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5, ifid_uses_rs2=1 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1. The same case with idex_rd=0 → no stall.
REQ-034 Branch: exmem_branch_taken=1 in RUN → all three flushes=1 and pc_write=1 that cycle; flush_cnt=1.
REQ-035 Memory stall: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 → freeze=1 for 3 cycles, release on the 4th, state returns to 0; stall_cnt=3.
REQ-036 Timeout (TIMEOUT=4): dmem_ready held 0 → state=2 and mem_err=1 after the 5th frozen cycle; outputs remain frozen while inputs change; reset returns state=0 and mem_err=0.
REQ-037 Simultaneous events: branch, load-use and memory stall asserted together → freeze only; on the release cycle → branch flush with no load-use stall.
REQ-038 Saturation: force 65536 or more stall cycles → stall_cnt holds at 0xFFFF.
